serial_adder_fsm: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fsm_full_adder_cell.sv | 33 +++
 rtl/serial_adder_fsm.sv | 136 +++++++++++++
 tb/tb_serial_adder_fsm.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_t     : controller state encoding (IDLE, RUN, DONE)
//   - cnt_width() : bit-counter width for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice even
    // when WIDTH is a power of two. Floor at 1 so the vector never collapses.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fsm_full_adder_cell.sv
// full_adder_cell
//   One-bit full adder built from two half-adder stages and an OR gate.
//   Ports:
//     x, y : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
module full_adder_cell
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // first half adder: operands
    assign w_s1 = x ^ y;
    assign w_c1 = x & y;

    // second half adder: partial sum with carry in
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;

    // at most one of the two stage carries can be set
    assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm
//   Bit-serial unsigned adder, LSB first, one bit per clock.
//   {cout, sum} = a + b + cin, produced WIDTH+1 cycles after an accepted start.
//   Parameters:
//     WIDTH : operand/sum width, 2..64
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset
//     start : request, sampled in IDLE or DONE only
//     a, b  : operands, captured on the accepted start
//     cin   : carry in, captured on the accepted start
//     busy  : high while the addition is running
//     done  : one-cycle pulse when the result is ready
//     sum   : result, held until the next accepted start
//     cout  : carry out of the MSB, held like sum
//     ovf   : signed overflow, held like sum
//             (present only when SERIAL_ADDER_OVF_EN is defined)
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;

    full_adder_cell u_fa (
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // sum fills from the MSB side; after WIDTH shifts bit 0 is the LSB
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this last bit
                        r_ovf   <= r_carry ^ w_co;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
module tb_serial_adder_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge: drives the request, follows it to the done pulse and
    // checks timing and result against plain arithmetic. With hold=0 it returns
    // at the negedge of the done cycle so the caller can chain a new start.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input bit poke, input bit hold, input string tag);
        logic [W:0] exp;
        longint     s_signed;
        bit         exp_ovf;
        int         n;
        int         busy_cnt;
        exp      = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        s_signed = longint'($signed(ta)) + longint'($signed(tb)) + longint'(tc);
        exp_ovf  = (s_signed > longint'(2**(W-1) - 1)) || (s_signed < -longint'(2**(W-1)));
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        // operands may change freely once captured
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 1;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (poke && n == 3) begin start = 1'b1; a = 8'hAA; end
            if (poke && n == 5) start = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_busycycles"}, 64'(busy_cnt), 64'(W));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
        chk({tag, "_cout"}, 64'(cout), 64'(exp[W]));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        if (hold) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, 64'(done), 64'd0);
            chk({tag, "_sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
            chk({tag, "_cout_hold"}, 64'(cout), 64'(exp[W]));
        end
    endtask

    initial begin
        int  seen_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum",  64'(sum),  64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, "carry");
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "cin_only");
        run_op(8'h0F, 8'h01, 1'b0, 1'b1, 1'b1, "ignored_start");

        // back-to-back: the second start is presented in the done cycle
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, "b2b_first");
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, "b2b_second");

        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, "signed_ovf");
        run_op(8'h80, 8'hFF, 1'b1, 1'b0, 1'b1, "neg_edge");

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1, "random");
        end

        // reset in RUN cycle 4, asserted between clock edges
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_sum",  64'(sum),  64'd0);
        chk("async_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("no_done_after_reset", 64'(seen_done), 64'd0);
        chk("idle_sum_after_reset", 64'(sum), 64'd0);

        run_op(8'h3C, 8'hC4, 1'b0, 1'b0, 1'b1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
